// File: rtl/sata_oob_pkg.sv
// Shared definitions for the SATA OOB controller: FSM state encoding, primitive
// DWORDs and the TX output mux select.
package sata_oob_pkg;

  typedef enum logic [3:0] {
    StComreset    = 4'd0,
    StWaitCominit = 4'd1,
    StComwake     = 4'd2,
    StWaitComwake = 4'd3,
    StSettle      = 4'd4,
    StDial        = 4'd5,
    StSendAlign   = 4'd6,
    StLinkReady   = 4'd7,
    StFail        = 4'd8
  } oob_state_e;

  localparam logic [31:0] PrimAlign = 32'h7B4A_4ABC;
  localparam logic [31:0] PrimSync  = 32'hB5B5_957C;
  localparam logic [31:0] PrimDial  = 32'h4A4A_4A4A;

  // TX mux select
  localparam logic [1:0] TxSelIdle  = 2'd0;  // ALIGN pattern, K=0 (line is idle)
  localparam logic [1:0] TxSelDial  = 2'd1;  // dial tone, K=0
  localparam logic [1:0] TxSelAlign = 2'd2;  // ALIGN, K=1
  localparam logic [1:0] TxSelData  = 2'd3;  // link-layer data with ALIGN insertion

  function automatic logic [1:0] tx_sel_for(input oob_state_e st);
    case (st)
      StDial:      return TxSelDial;
      StSendAlign: return TxSelAlign;
      StLinkReady: return TxSelData;
      default:     return TxSelIdle;
    endcase
  endfunction

  // States in which the transmitter is out of electrical idle and RX data is forwarded
  function automatic logic is_active(input oob_state_e st);
    return (st == StDial) || (st == StSendAlign) || (st == StLinkReady);
  endfunction

endpackage

// File: rtl/sata_align_inserter.sv
// ALIGN insertion: period counter running while the link is up, align_en
// generation and the registered TX output mux. All inputs describe the next
// cycle, so the registered outputs line up with the FSM state register.
module sata_align_inserter
  import sata_oob_pkg::*;
#(
  parameter int unsigned ALIGN_PERIOD = 256,
  parameter int unsigned ALIGN_BURST  = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  tx_sel,
  input  logic [31:0] tx_datain,
  input  logic        tx_charisk_in,
  output logic [31:0] tx_dataout,
  output logic        tx_charisk_out,
  output logic        align_en_out
);

  localparam int unsigned CntW = $clog2(ALIGN_PERIOD);
  localparam logic [CntW-1:0] PeriodLast = CntW'(ALIGN_PERIOD - 1);
  localparam logic [CntW-1:0] BurstLen   = CntW'(ALIGN_BURST);

  logic [CntW-1:0] cnt_d, cnt_q;
  logic            run_d, run_q;
  logic            align_en_d, align_en_q;
  logic [31:0]     tx_data_d, tx_data_q;
  logic            tx_k_d, tx_k_q;

  // Next slot count and TX word; count restarts at 0 on the first data cycle
  always_comb begin
    run_d = (tx_sel == TxSelData);
    cnt_d = '0;
    if (run_d && run_q) begin
      cnt_d = (cnt_q == PeriodLast) ? '0 : cnt_q + CntW'(1);
    end
    align_en_d = run_d && (cnt_d < BurstLen);

    tx_data_d = PrimAlign;
    tx_k_d    = 1'b0;
    case (tx_sel)
      TxSelDial:  tx_data_d = PrimDial;
      TxSelAlign: tx_k_d = 1'b1;
      TxSelData: begin
        if (align_en_d) begin
          tx_k_d = 1'b1;
        end else begin
          tx_data_d = tx_datain;
          tx_k_d    = tx_charisk_in;
        end
      end
      default: ;
    endcase
  end

  // Output and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      run_q      <= 1'b0;
      align_en_q <= 1'b0;
      tx_data_q  <= PrimAlign;
      tx_k_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      run_q      <= run_d;
      align_en_q <= align_en_d;
      tx_data_q  <= tx_data_d;
      tx_k_q     <= tx_k_d;
    end
  end

  assign tx_dataout     = tx_data_q;
  assign tx_charisk_out = tx_k_q;
  assign align_en_out   = align_en_q;

endmodule

// File: rtl/sata_oob_speed_neg.sv
// SATA OOB link initialisation with Gen2 -> Gen1 speed fallback, link-loss
// recovery and periodic ALIGN insertion on the TX stream.
module sata_oob_speed_neg
  import sata_oob_pkg::*;
#(
  parameter int unsigned COMRESET_CYC_G1 = 81,
  parameter int unsigned COMRESET_CYC_G2 = 162,
  parameter int unsigned COMWAKE_CYC_G1  = 78,
  parameter int unsigned COMWAKE_CYC_G2  = 155,
  parameter int unsigned TIMEOUT_CYC     = 132013,
  parameter int unsigned SETTLE_CYC      = 63,
  parameter int unsigned LOSS_CYC        = 1024,
  parameter int unsigned MAX_RETRIES     = 4,
  parameter int unsigned ALIGN_PERIOD    = 256,
  parameter int unsigned ALIGN_BURST     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        link_reset,
  input  logic        rx_locked,
  input  logic        cominitdet,
  input  logic        comwakedet,
  input  logic        rxelecidle,
  input  logic        rxbyteisaligned,
  input  logic [31:0] rx_datain,
  input  logic [3:0]  rx_charisk_in,
  input  logic [31:0] tx_datain,
  input  logic        tx_charisk_in,
  output logic        gen2,
  output logic        rxreset,
  output logic        txcominit,
  output logic        txcomwake,
  output logic        txelecidle_out,
  output logic [31:0] tx_dataout,
  output logic        tx_charisk_out,
  output logic [31:0] rx_dataout,
  output logic [3:0]  rx_charisk_out,
  output logic        linkup,
  output logic        align_en_out,
  output logic        link_fail,
  output logic [3:0]  state_out
);

  localparam logic [17:0] TimeoutLast = 18'(TIMEOUT_CYC - 1);
  localparam logic [17:0] LossLast    = 18'(LOSS_CYC - 1);
  localparam logic [17:0] SettleCyc   = 18'(SETTLE_CYC);
  localparam logic [3:0]  MaxRetries  = 4'(MAX_RETRIES);

  // Registered GTX status and RX data
  logic        rx_locked_q, cominit_q, comwake_q, elecidle_q, byte_al_q;
  logic [31:0] rx_data_q;
  logic [3:0]  rx_charisk_q;

  oob_state_e  state_d, state_q;
  logic [17:0] cnt_d, cnt_q;
  logic [3:0]  retry_d, retry_q, retry_inc;
  logic        gen2_d, gen2_q;
  logic        txcominit_d, txcominit_q;
  logic        txcomwake_d, txcomwake_q;
  logic        txelecidle_d, txelecidle_q;
  logic        rxreset_d, rxreset_q;
  logic        linkup_d, linkup_q;
  logic        link_fail_d, link_fail_q;
  logic [17:0] comreset_len, comwake_len;
  logic        timeout, align_det, sync_det;
  logic [1:0]  tx_sel_d;

  // Input capture stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_locked_q  <= 1'b0;
      cominit_q    <= 1'b0;
      comwake_q    <= 1'b0;
      elecidle_q   <= 1'b0;
      byte_al_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_charisk_q <= '0;
    end else begin
      rx_locked_q  <= rx_locked;
      cominit_q    <= cominitdet;
      comwake_q    <= comwakedet;
      elecidle_q   <= rxelecidle;
      byte_al_q    <= rxbyteisaligned;
      rx_data_q    <= rx_datain;
      rx_charisk_q <= rx_charisk_in;
    end
  end

  // FSM next state, shared state counter, retry bookkeeping and registered outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    gen2_d      = gen2_q;
    txcominit_d = 1'b0;
    txcomwake_d = 1'b0;
    rxreset_d   = 1'b0;
    linkup_d    = linkup_q;
    link_fail_d = link_fail_q;
    retry_inc   = retry_q + 4'd1;

    comreset_len = gen2_q ? 18'(COMRESET_CYC_G2) : 18'(COMRESET_CYC_G1);
    comwake_len  = gen2_q ? 18'(COMWAKE_CYC_G2) : 18'(COMWAKE_CYC_G1);
    timeout      = (cnt_q == TimeoutLast);
    align_det    = (rx_data_q == PrimAlign) && byte_al_q;
    sync_det     = (rx_data_q == PrimSync);

    case (state_q)
      StComreset: begin
        // Once started, the burst runs to completion even if lock drops
        if (rx_locked_q || txcominit_q) begin
          if (cnt_q == comreset_len) begin
            state_d = StWaitCominit;
            cnt_d   = '0;
          end else begin
            txcominit_d = 1'b1;
            cnt_d       = cnt_q + 18'd1;
          end
        end
      end
      StWaitCominit: begin
        if (cominit_q) begin
          state_d = StComwake;
          cnt_d   = '0;
        end else if (timeout) begin
          state_d = StFail;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 18'd1;
        end
      end
      StComwake: begin
        if (cnt_q == comwake_len) begin
          state_d = StWaitComwake;
          cnt_d   = '0;
        end else begin
          txcomwake_d = 1'b1;
          cnt_d       = cnt_q + 18'd1;
        end
      end
      StWaitComwake: begin
        if (comwake_q) begin
          state_d = StSettle;
          cnt_d   = '0;
        end else if (timeout) begin
          state_d = StFail;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 18'd1;
        end
      end
      StSettle: begin
        if (cnt_q != SettleCyc) begin
          cnt_d = cnt_q + 18'd1;
        end else if (!elecidle_q) begin
          rxreset_d = 1'b1;
          state_d   = StDial;
          cnt_d     = '0;
        end
      end
      StDial: begin
        if (align_det) begin
          state_d = StSendAlign;
          cnt_d   = '0;
        end else if (timeout) begin
          state_d = StFail;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 18'd1;
        end
      end
      StSendAlign: begin
        if (sync_det) begin
          state_d  = StLinkReady;
          cnt_d    = '0;
          linkup_d = 1'b1;
          retry_d  = '0;
        end
      end
      StLinkReady: begin
        // Counter holds the length of the current rxelecidle run
        if (elecidle_q) begin
          if (cnt_q == LossLast) begin
            state_d  = StComreset;
            cnt_d    = '0;
            linkup_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 18'd1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      StFail: begin
        state_d = StComreset;
        cnt_d   = '0;
        if (retry_inc < MaxRetries) begin
          retry_d = retry_inc;
        end else if (gen2_q) begin
          gen2_d  = 1'b0;
          retry_d = '0;
        end else begin
          link_fail_d = 1'b1;
          gen2_d      = 1'b1;
          retry_d     = '0;
        end
      end
      default: begin
        state_d = StComreset;
        cnt_d   = '0;
      end
    endcase

    if (link_reset) begin
      state_d     = StComreset;
      cnt_d       = '0;
      retry_d     = '0;
      linkup_d    = 1'b0;
      gen2_d      = 1'b1;
      txcominit_d = 1'b0;
      txcomwake_d = 1'b0;
      rxreset_d   = 1'b0;
    end

    txelecidle_d = !is_active(state_d);
    tx_sel_d     = tx_sel_for(state_d);
  end

  // FSM state and registered control outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StComreset;
      cnt_q        <= '0;
      retry_q      <= '0;
      gen2_q       <= 1'b1;
      txcominit_q  <= 1'b0;
      txcomwake_q  <= 1'b0;
      txelecidle_q <= 1'b1;
      rxreset_q    <= 1'b0;
      linkup_q     <= 1'b0;
      link_fail_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      gen2_q       <= gen2_d;
      txcominit_q  <= txcominit_d;
      txcomwake_q  <= txcomwake_d;
      txelecidle_q <= txelecidle_d;
      rxreset_q    <= rxreset_d;
      linkup_q     <= linkup_d;
      link_fail_q  <= link_fail_d;
    end
  end

  sata_align_inserter #(
    .ALIGN_PERIOD (ALIGN_PERIOD),
    .ALIGN_BURST  (ALIGN_BURST)
  ) u_align_inserter (
    .clk            (clk),
    .reset_n        (reset_n),
    .tx_sel         (tx_sel_d),
    .tx_datain      (tx_datain),
    .tx_charisk_in  (tx_charisk_in),
    .tx_dataout     (tx_dataout),
    .tx_charisk_out (tx_charisk_out),
    .align_en_out   (align_en_out)
  );

  assign gen2           = gen2_q;
  assign rxreset        = rxreset_q;
  assign txcominit      = txcominit_q;
  assign txcomwake      = txcomwake_q;
  assign txelecidle_out = txelecidle_q;
  assign linkup         = linkup_q;
  assign link_fail      = link_fail_q;
  assign state_out      = state_q;
  assign rx_dataout     = is_active(state_q) ? rx_data_q : '0;
  assign rx_charisk_out = (state_q == StLinkReady) ? rx_charisk_q : '0;

endmodule

// File: tb/tb_sata_oob_speed_neg.sv
// Directed bench for sata_oob_speed_neg: bring-up, ALIGN insertion table,
// link loss, DIAL timeout, speed fallback, link_reset and async reset.
module tb_sata_oob_speed_neg;

  localparam logic [31:0] ALIGN = 32'h7B4A_4ABC;
  localparam logic [31:0] SYNC  = 32'hB5B5_957C;
  localparam logic [31:0] DIAL  = 32'h4A4A_4A4A;
  localparam int TOUT = 300;

  logic        clk = 1'b0;
  logic        reset_n, link_reset, rx_locked, cominitdet, comwakedet;
  logic        rxelecidle, rxbyteisaligned, tx_charisk_in;
  logic [31:0] rx_datain, tx_datain;
  logic [3:0]  rx_charisk_in;
  logic        gen2, rxreset, txcominit, txcomwake, txelecidle_out, tx_charisk_out;
  logic        linkup, align_en_out, link_fail;
  logic [31:0] tx_dataout, rx_dataout;
  logic [3:0]  rx_charisk_out, state_out;

  int n_err = 0;
  int n_checks = 0;
  int s, len, fails, waits, n;

  typedef struct {
    int          slot;
    logic [31:0] din;
    logic        kin;
    logic [31:0] dout;
    logic        kout;
    logic        aen;
  } tx_vec_t;
  tx_vec_t vecs[10];

  sata_oob_speed_neg #(
    .TIMEOUT_CYC (TOUT)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .link_reset      (link_reset),
    .rx_locked       (rx_locked),
    .cominitdet      (cominitdet),
    .comwakedet      (comwakedet),
    .rxelecidle      (rxelecidle),
    .rxbyteisaligned (rxbyteisaligned),
    .rx_datain       (rx_datain),
    .rx_charisk_in   (rx_charisk_in),
    .tx_datain       (tx_datain),
    .tx_charisk_in   (tx_charisk_in),
    .gen2            (gen2),
    .rxreset         (rxreset),
    .txcominit       (txcominit),
    .txcomwake       (txcomwake),
    .txelecidle_out  (txelecidle_out),
    .tx_dataout      (tx_dataout),
    .tx_charisk_out  (tx_charisk_out),
    .rx_dataout      (rx_dataout),
    .rx_charisk_out  (rx_charisk_out),
    .linkup          (linkup),
    .align_en_out    (align_en_out),
    .link_fail       (link_fail),
    .state_out       (state_out)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return txcominit;
      1:       return txcomwake;
      2:       return linkup;
      3:       return gen2;
      4:       return link_fail;
      default: return rxreset;
    endcase
  endfunction

  task automatic expire(input string name, input int max);
    n_checks++;
    n_err++;
    $display("FAIL %s: wait expired after %0d cycles", name, max);
  endtask

  task automatic wait_sig(input int sel, input logic val, input int max, input string name);
    int k = 0;
    while (sig(sel) !== val && k < max) begin
      step();
      k++;
    end
    if (sig(sel) !== val) expire(name, max);
  endtask

  task automatic wait_state(input logic [3:0] st, input int max, input string name);
    int k = 0;
    while (state_out !== st && k < max) begin
      step();
      k++;
    end
    if (state_out !== st) expire(name, max);
  endtask

  task automatic pulse_len(input int sel, input string name, output int l);
    wait_sig(sel, 1'b1, 100, name);
    l = 0;
    while (sig(sel) === 1'b1 && l < 1000) begin
      step();
      l++;
    end
  endtask

  // Run until sig(sel)==val, counting FAIL visits and WAIT_COMINIT cycles
  task automatic run_fails(input int sel, input logic val, input string name,
                           output int f, output int w);
    int k = 0;
    f = 0;
    w = 0;
    while (sig(sel) !== val && k < 6000) begin
      step();
      k++;
      if (state_out == 4'd8) f++;
      if (state_out == 4'd1) w++;
    end
    if (sig(sel) !== val) expire(name, 6000);
  endtask

  task automatic bring_to_dial();
    wait_sig(0, 1'b1, 100, "dial_cominit_start");
    wait_sig(0, 1'b0, 400, "dial_cominit_end");
    repeat (20) step();
    cominitdet = 1'b1;
    step();
    cominitdet = 1'b0;
    wait_sig(1, 1'b1, 50, "dial_comwake_start");
    wait_sig(1, 1'b0, 400, "dial_comwake_end");
    repeat (30) step();
    comwakedet = 1'b1;
    step();
    comwakedet = 1'b0;
    rxelecidle = 1'b0;
    wait_state(4'd5, 200, "dial_entry");
  endtask

  initial begin
    vecs[0] = '{1,   32'h1111_1111, 1'b0, ALIGN,          1'b1, 1'b1};
    vecs[1] = '{2,   32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 1'b0};
    vecs[2] = '{3,   32'hCAFE_BABE, 1'b1, 32'hCAFE_BABE, 1'b1, 1'b0};
    vecs[3] = '{100, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[4] = '{255, 32'h0F0F_0F0F, 1'b0, 32'h0F0F_0F0F, 1'b0, 1'b0};
    vecs[5] = '{256, 32'hAAAA_5555, 1'b0, ALIGN,          1'b1, 1'b1};
    vecs[6] = '{257, 32'h5555_5555, 1'b1, ALIGN,          1'b1, 1'b1};
    vecs[7] = '{258, 32'h8765_4321, 1'b0, 32'h8765_4321, 1'b0, 1'b0};
    vecs[8] = '{512, 32'h0000_0001, 1'b0, ALIGN,          1'b1, 1'b1};
    vecs[9] = '{514, 32'h0000_0002, 1'b1, 32'h0000_0002, 1'b1, 1'b0};

    reset_n = 1'b0;
    link_reset = 1'b0;
    rx_locked = 1'b0;
    cominitdet = 1'b0;
    comwakedet = 1'b0;
    rxelecidle = 1'b1;
    rxbyteisaligned = 1'b0;
    rx_datain = '0;
    rx_charisk_in = 4'b0001;
    tx_datain = '0;
    tx_charisk_in = 1'b0;
    repeat (3) step();

    // Reset values
    check("rst_state", state_out, 4'd0);
    check("rst_gen2", gen2, 1'b1);
    check("rst_txelecidle", txelecidle_out, 1'b1);
    check("rst_tx_data", tx_dataout, ALIGN);
    check("rst_tx_k", tx_charisk_out, 1'b0);
    check("rst_linkup", linkup, 1'b0);
    check("rst_link_fail", link_fail, 1'b0);
    check("rst_strobes", {txcominit, txcomwake, rxreset, align_en_out}, 4'b0000);

    // Bring-up at Gen2
    reset_n = 1'b1;
    rx_locked = 1'b1;
    pulse_len(0, "t1_cominit", len);
    check("t1_comreset_len_g2", len, 162);
    repeat (19) step();
    cominitdet = 1'b1;
    step();
    cominitdet = 1'b0;
    pulse_len(1, "t1_comwake", len);
    check("t1_comwake_len_g2", len, 155);
    repeat (29) step();
    comwakedet = 1'b1;
    step();
    comwakedet = 1'b0;
    rxelecidle = 1'b0;
    wait_state(4'd5, 200, "t1_dial");
    check("t1_rxreset_pulse", rxreset, 1'b1);
    check("t1_dial_tx", tx_dataout, DIAL);
    check("t1_dial_k", tx_charisk_out, 1'b0);
    check("t1_dial_txidle", txelecidle_out, 1'b0);
    step();
    check("t1_rxreset_one_cycle", rxreset, 1'b0);
    rx_datain = ALIGN;
    rxbyteisaligned = 1'b1;
    wait_state(4'd6, 10, "t1_send_align");
    check("t1_send_align_tx", tx_dataout, ALIGN);
    check("t1_send_align_k", tx_charisk_out, 1'b1);
    rx_datain = SYNC;
    step();
    step();
    check("t1_ready_state", state_out, 4'd7);
    check("t1_linkup", linkup, 1'b1);
    check("t1_gen2", gen2, 1'b1);
    check("t1_slot0_align_en", align_en_out, 1'b1);
    check("t1_slot0_tx", tx_dataout, ALIGN);
    check("t1_rx_data", rx_dataout, SYNC);
    check("t1_rx_k", rx_charisk_out, 4'b0001);

    // ALIGN insertion table, slot index counted from the first LINK_READY cycle
    s = 0;
    foreach (vecs[i]) begin
      while (s < vecs[i].slot - 1) begin
        step();
        s++;
      end
      tx_datain = vecs[i].din;
      tx_charisk_in = vecs[i].kin;
      step();
      s++;
      check($sformatf("t4_data_slot%0d", vecs[i].slot), tx_dataout, vecs[i].dout);
      check($sformatf("t4_k_slot%0d", vecs[i].slot), tx_charisk_out, vecs[i].kout);
      check($sformatf("t4_aen_slot%0d", vecs[i].slot), align_en_out, vecs[i].aen);
    end
    n = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (align_en_out) n++;
    end
    check("t4_align_per_period", n, 2);

    // Link loss: 1023 idle cycles tolerated, 1024 drop the link
    rxelecidle = 1'b1;
    repeat (1023) step();
    rxelecidle = 1'b0;
    repeat (3) step();
    check("t5_1023_linkup", linkup, 1'b1);
    check("t5_1023_state", state_out, 4'd7);
    rxelecidle = 1'b1;
    repeat (1024) step();
    rxelecidle = 1'b0;
    check("t5_1024_before", linkup, 1'b1);
    step();
    check("t5_1024_linkup", linkup, 1'b0);
    check("t5_1024_state", state_out, 4'd0);
    check("t5_1024_gen2", gen2, 1'b1);
    check("t5_rx_data_gated", rx_dataout, 32'h0);

    // ALIGN without byte alignment must not leave DIAL before the timeout
    rx_datain = ALIGN;
    rxbyteisaligned = 1'b0;
    bring_to_dial();
    check("t3_dial_rx_data", rx_dataout, ALIGN);
    check("t3_dial_rx_k", rx_charisk_out, 4'b0000);
    n = 0;
    while (state_out == 4'd5 && n < 1000) begin
      n++;
      step();
    end
    check("t3_dial_cycles", n, TOUT);
    check("t3_after_dial", state_out, 4'd8);
    step();
    check("t3_fail_to_comreset", state_out, 4'd0);

    // Speed fallback with no COMINIT ever
    link_reset = 1'b1;
    step();
    link_reset = 1'b0;
    check("t2_lr_state", state_out, 4'd0);
    run_fails(3, 1'b0, "t2_gen2_drop", fails, waits);
    check("t2_fails_gen2", fails, 4);
    check("t2_wait_cominit_cycles", waits, 4 * TOUT);
    check("t2_fallback_state", state_out, 4'd0);
    pulse_len(0, "t2_cominit_g1", len);
    check("t2_comreset_len_g1", len, 81);
    run_fails(4, 1'b1, "t2_link_fail", fails, waits);
    check("t2_fails_gen1", fails, 4);
    check("t2_link_fail_gen2", gen2, 1'b1);

    // link_reset mid-COMWAKE at Gen1 after two failures
    run_fails(3, 1'b0, "t6_gen2_drop", fails, waits);
    check("t6_fails_gen2", fails, 4);
    n = 0;
    fails = 0;
    while (fails < 2 && n < 2000) begin
      step();
      n++;
      if (state_out == 4'd8) fails++;
    end
    if (fails < 2) expire("t6_two_fails", 2000);
    wait_sig(0, 1'b1, 100, "t6_cominit_start");
    wait_sig(0, 1'b0, 200, "t6_cominit_end");
    repeat (5) step();
    cominitdet = 1'b1;
    step();
    cominitdet = 1'b0;
    wait_sig(1, 1'b1, 50, "t6_comwake_start");
    repeat (10) step();
    check("t6_mid_comwake_gen2", gen2, 1'b0);
    link_reset = 1'b1;
    step();
    link_reset = 1'b0;
    check("t6_lr_state", state_out, 4'd0);
    check("t6_lr_gen2", gen2, 1'b1);
    check("t6_lr_txcomwake", txcomwake, 1'b0);
    check("t6_lr_link_fail_kept", link_fail, 1'b1);
    run_fails(3, 1'b0, "t6_retries_cleared", fails, waits);
    check("t6_fails_after_lr", fails, 4);

    // Asynchronous reset in the middle of a COMRESET burst
    wait_sig(0, 1'b1, 100, "t6_burst");
    repeat (10) step();
    reset_n = 1'b0;
    #1;
    check("t6_rst_txcominit", txcominit, 1'b0);
    check("t6_rst_state", state_out, 4'd0);
    check("t6_rst_gen2", gen2, 1'b1);
    check("t6_rst_link_fail", link_fail, 1'b0);
    check("t6_rst_txelecidle", txelecidle_out, 1'b1);
    step();
    reset_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
